// File: rtl/anim_pkg.sv
// Shared types and clip table for the sprite animation sequencer.
package anim_pkg;

    localparam int NUM_STATES = 6;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WALK   = 4'd1,
        RUN    = 4'd2,
        JUMP   = 4'd3,
        CROUCH = 4'd4,
        FALL   = 4'd5
    } movement_state_t;

    typedef enum logic {
        SEQ_PLAY = 1'b0,
        SEQ_DONE = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [2:0] base_row;
        logic [2:0] frames;
        logic [2:0] hold;
        logic       loop;
    } clip_t;

    localparam clip_t CLIP_TABLE [0:NUM_STATES-1] = '{
        '{base_row: 3'd0, frames: 3'd2, hold: 3'd4, loop: 1'b1},  // IDLE
        '{base_row: 3'd1, frames: 3'd4, hold: 3'd2, loop: 1'b1},  // WALK
        '{base_row: 3'd2, frames: 3'd4, hold: 3'd1, loop: 1'b1},  // RUN
        '{base_row: 3'd3, frames: 3'd3, hold: 3'd2, loop: 1'b0},  // JUMP
        '{base_row: 3'd4, frames: 3'd1, hold: 3'd1, loop: 1'b0},  // CROUCH
        '{base_row: 3'd5, frames: 3'd2, hold: 3'd3, loop: 1'b1}   // FALL
    };

    // Unused encodings fall back to IDLE so the table index is always valid.
    function automatic movement_state_t sanitize(input logic [3:0] raw);
        return (raw > 4'd5) ? IDLE : movement_state_t'(raw);
    endfunction

    function automatic clip_t clip_lookup(input movement_state_t s);
        return CLIP_TABLE[s[2:0]];
    endfunction

endpackage

// File: rtl/anim_frame_counter.sv
// Hold/frame counter and PLAY/DONE sequencing for one clip.
// Optional bounce playback for looping clips under `ANIM_PINGPONG_EN.
module anim_frame_counter
    import anim_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  clip_t      clip,
    input  logic       tick,
    input  logic       restart,
    // Next-state values; the parent registers them into its outputs.
    output logic [1:0] frame_idx,
    output logic       strobe,
    output logic       done
);

    seq_state_t seq_q, seq_d;
    logic [1:0] frame_q, frame_d;
    logic [1:0] hold_q, hold_d;
    logic       last_frame, hold_end;

`ifdef ANIM_PINGPONG_EN
    logic dir_dn_q, dir_dn_d;
`endif

    assign last_frame = ({1'b0, frame_q} == (clip.frames - 3'd1));
    assign hold_end   = ({1'b0, hold_q}  == (clip.hold   - 3'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q    <= SEQ_PLAY;
            frame_q  <= 2'd0;
            hold_q   <= 2'd0;
`ifdef ANIM_PINGPONG_EN
            dir_dn_q <= 1'b0;
`endif
        end else begin
            seq_q    <= seq_d;
            frame_q  <= frame_d;
            hold_q   <= hold_d;
`ifdef ANIM_PINGPONG_EN
            dir_dn_q <= dir_dn_d;
`endif
        end
    end

    always_comb begin
        seq_d    = seq_q;
        frame_d  = frame_q;
        hold_d   = hold_q;
        strobe   = 1'b0;
`ifdef ANIM_PINGPONG_EN
        dir_dn_d = dir_dn_q;
`endif
        if (restart) begin
            seq_d    = SEQ_PLAY;
            frame_d  = 2'd0;
            hold_d   = 2'd0;
`ifdef ANIM_PINGPONG_EN
            dir_dn_d = 1'b0;
`endif
        end else if (tick && seq_q == SEQ_PLAY) begin
            if (hold_end) begin
                hold_d = 2'd0;
                if (last_frame && !clip.loop) begin
                    seq_d = SEQ_DONE;
`ifdef ANIM_PINGPONG_EN
                end else if (clip.loop && clip.frames > 3'd2) begin
                    if (!dir_dn_q) begin
                        if (last_frame) begin
                            frame_d  = frame_q - 2'd1;
                            dir_dn_d = 1'b1;
                        end else begin
                            frame_d  = frame_q + 2'd1;
                        end
                    end else if (frame_q == 2'd0) begin
                        frame_d  = 2'd1;
                        dir_dn_d = 1'b0;
                    end else begin
                        frame_d  = frame_q - 2'd1;
                    end
`endif
                end else if (last_frame) begin
                    frame_d = 2'd0;
                end else begin
                    frame_d = frame_q + 2'd1;
                end
                // Single-frame one-shots finish without a visible change.
                strobe = (frame_d != frame_q);
            end else begin
                hold_d = hold_q + 2'd1;
            end
        end
        frame_idx = frame_d;
        done      = (seq_d == SEQ_DONE);
    end

endmodule

// File: rtl/anim_sequencer.sv
// Per-player sprite animation sequencer: movement state + anim_tick -> sheet offsets.
// Build option: `ANIM_PINGPONG_EN enables bounce playback of looping clips.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int FRAME_W    = 23,
    parameter int FRAME_H    = 30,
    parameter int SHEET_COLS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        anim_tick,
    input  logic [3:0]  move_state,
    output logic [10:0] anim_row,
    output logic [10:0] anim_col,
    output logic [6:0]  sheet_width,
    output logic        frame_strobe,
    output logic        anim_done
);

    movement_state_t cur_state, new_state;
    clip_t           cur_clip, new_clip;
    logic            restart;
    logic [1:0]      frame_nxt;
    logic            strobe_nxt, done_nxt;

    assign new_state   = sanitize(move_state);
    assign restart     = (new_state != cur_state);
    assign cur_clip    = clip_lookup(cur_state);
    assign new_clip    = clip_lookup(new_state);
    assign sheet_width = 7'(FRAME_W * SHEET_COLS);

    anim_frame_counter u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clip      (cur_clip),
        .tick      (anim_tick),
        .restart   (restart),
        .frame_idx (frame_nxt),
        .strobe    (strobe_nxt),
        .done      (done_nxt)
    );

    // Registered from next-state values so a change is visible one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= IDLE;
            anim_row     <= 11'd0;
            anim_col     <= 11'd0;
            frame_strobe <= 1'b0;
            anim_done    <= 1'b0;
        end else begin
            cur_state    <= new_state;
            anim_row     <= 11'(new_clip.base_row) * 11'(FRAME_H);
            anim_col     <= 11'(frame_nxt) * 11'(FRAME_W);
            frame_strobe <= strobe_nxt;
            anim_done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Randomized + directed bench for anim_sequencer against a tick-count reference model.
module tb_anim_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        anim_tick;
    logic [3:0]  move_state;
    logic [10:0] anim_row, anim_col;
    logic [6:0]  sheet_width;
    logic        frame_strobe, anim_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    anim_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .anim_tick    (anim_tick),
        .move_state   (move_state),
        .anim_row     (anim_row),
        .anim_col     (anim_col),
        .sheet_width  (sheet_width),
        .frame_strobe (frame_strobe),
        .anim_done    (anim_done)
    );

    // Clip table: base_row, frames, hold, loop
    int base_t  [6] = '{0, 1, 2, 3, 4, 5};
    int frames_t[6] = '{2, 4, 4, 3, 1, 2};
    int hold_t  [6] = '{4, 2, 1, 2, 1, 3};
    int loop_t  [6] = '{1, 1, 1, 0, 0, 1};

    // Model: frame position is derived from the count of accepted ticks since the clip started.
    int m_st, m_ticks, m_frame, m_done, m_strobe;

    function automatic int frame_of(int st, int ticks);
        int n, period, p;
        n = ticks / hold_t[st];
        if (loop_t[st] == 0) return (n < frames_t[st]) ? n : frames_t[st] - 1;
`ifdef ANIM_PINGPONG_EN
        if (frames_t[st] > 2) begin
            period = 2 * (frames_t[st] - 1);
            p = n % period;
            return (p < frames_t[st]) ? p : period - p;
        end
`endif
        period = 0;
        p = 0;
        return n % frames_t[st] + period + p;
    endfunction

    function automatic int done_of(int st, int ticks);
        return (loop_t[st] == 0 && ticks / hold_t[st] >= frames_t[st]) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ticks = 0; m_frame = 0; m_done = 0; m_strobe = 0;
    endtask

    task automatic cyc(input logic t, input logic [3:0] m);
        int san, nf;
        @(negedge clk);
        anim_tick  = t;
        move_state = m;
        san = (m > 4'd5) ? 0 : int'(m);
        m_strobe = 0;
        if (san != m_st) begin
            m_st = san; m_ticks = 0; m_frame = 0;
        end else if (t && m_done == 0) begin
            m_ticks++;
            nf = frame_of(m_st, m_ticks);
            m_strobe = (nf != m_frame) ? 1 : 0;
            m_frame = nf;
        end
        m_done = done_of(m_st, m_ticks);
        @(posedge clk);
        #1;
        chk("row",    int'(anim_row),     base_t[m_st] * 30);
        chk("col",    int'(anim_col),     m_frame * 23);
        chk("strobe", int'(frame_strobe), m_strobe);
        chk("done",   int'(anim_done),    m_done);
    endtask

    int walk_col[9] = '{0, 23, 23, 46, 46, 69, 69, 0, 0};
    int pp_col[8]   = '{23, 46, 69, 46, 23, 0, 23, 46};
    logic [3:0] ms;

    initial begin
        rst_n = 1'b0; anim_tick = 1'b0; move_state = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row",   int'(anim_row), 0);
        chk("rst_col",   int'(anim_col), 0);
        chk("rst_strb",  int'(frame_strobe), 0);
        chk("rst_done",  int'(anim_done), 0);
        chk("sheet_w",   int'(sheet_width), 92);
        @(negedge clk) rst_n = 1'b1;

        // WALK held for 9 ticks
        cyc(1'b0, 4'd1);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 4'd1);
            chk("walk_row", int'(anim_row), 30);
            chk("walk_col", int'(anim_col), walk_col[i]);
            chk("walk_strb", int'(frame_strobe), (i % 2 == 1) ? 1 : 0);
        end

        // JUMP one-shot, 8 ticks
        cyc(1'b0, 4'd3);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 4'd3);
            chk("jump_done", int'(anim_done), (i >= 6) ? 1 : 0);
            if (i >= 7) chk("jump_strb", int'(frame_strobe), 0);
        end
        chk("jump_row", int'(anim_row), 90);
        chk("jump_col", int'(anim_col), 46);

        // CROUCH single-frame one-shot
        cyc(1'b0, 4'd4);
        cyc(1'b1, 4'd4);
        chk("crouch_done", int'(anim_done), 1);

        // State change coincident with tick
        cyc(1'b0, 4'd1);
        cyc(1'b1, 4'd1);
        cyc(1'b1, 4'd1);
        chk("pre_chg_col", int'(anim_col), 23);
        cyc(1'b1, 4'd2);
        chk("chg_row", int'(anim_row), 60);
        chk("chg_col", int'(anim_col), 0);
        chk("chg_strb", int'(frame_strobe), 0);

        // Illegal encoding sanitized to IDLE
        cyc(1'b0, 4'd1);
        cyc(1'b1, 4'd1);
        cyc(1'b1, 4'd1);
        cyc(1'b0, 4'hF);
        chk("san_row", int'(anim_row), 0);
        chk("san_col", int'(anim_col), 0);

`ifdef ANIM_PINGPONG_EN
        cyc(1'b0, 4'd2);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 4'd2);
            chk("pp_col", int'(anim_col), pp_col[i]);
        end
`endif

        // Randomized traffic
        ms = 4'd1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) ms = 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), ms);
        end

        // Reset mid-play: WALK at frame 2, asynchronous clear between edges
        cyc(1'b0, 4'd1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'd1);
        chk("pre_rst_col", int'(anim_col), 46);
        @(negedge clk);
        anim_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_col",  int'(anim_col), 0);
        chk("async_row",  int'(anim_row), 0);
        chk("async_done", int'(anim_done), 0);
        model_reset();
        @(negedge clk);
        move_state = 4'd0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b1, 4'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
